// File: rtl/am_pkg.sv
// Shared definitions for the 40GBASE-R receive alignment controller.
package am_pkg;

    localparam int LANE_N_DEF    = 4;
    localparam int LANE_W_DEF    = $clog2(LANE_N_DEF);
    localparam int TIMEOUT_N_DEF = 65535;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_CHECK     = 2'd1,
        ST_DESKEW    = 2'd2,
        ST_ALIGNED   = 2'd3
    } am_state_e;

endpackage

// File: rtl/am_lane_map_chk.sv
// Combinational check that per-lane PCS identities form a permutation,
// plus one-hot to index encoding into the reorder map format.
module am_lane_map_chk
    import am_pkg::*;
#(
    parameter int LANE_N = LANE_N_DEF,
    parameter int LANE_W = $clog2(LANE_N)
) (
    input  logic [LANE_N*LANE_N-1:0] i_lane,
    output logic                     o_perm_ok,
    output logic [LANE_N*LANE_W-1:0] o_map
);

    logic [LANE_N-1:0] w_slice;
    logic [LANE_N-1:0] w_or_all;
    logic              w_all_onehot;

    // Validate each slice as one-hot, accumulate coverage, and place each
    // physical lane index into the slot of the PCS lane it carries.
    always_comb begin
        w_slice      = '0;
        w_or_all     = '0;
        w_all_onehot = 1'b1;
        o_map        = '0;
        for (int p = 0; p < LANE_N; p++) begin
            w_slice = i_lane[p*LANE_N +: LANE_N];
            if ((w_slice == '0) || ((w_slice & (w_slice - LANE_N'(1))) != '0)) begin
                w_all_onehot = 1'b0;
            end
            w_or_all = w_or_all | w_slice;
            for (int l = 0; l < LANE_N; l++) begin
                if (w_slice[l]) begin
                    o_map[l*LANE_W +: LANE_W] = o_map[l*LANE_W +: LANE_W] | LANE_W'(p);
                end
            end
        end
        o_perm_ok = w_all_onehot && (&w_or_all);
    end

endmodule

// File: rtl/am_align_ctrl_rx.sv
// Receive-side multi-lane alignment controller: waits for AM lock on all
// lanes, validates lane identities, programs the reorder map, sequences the
// deskew buffer and reports alignment, restarting lanes that stall.
module am_align_ctrl_rx
    import am_pkg::*;
#(
    parameter int LANE_N    = LANE_N_DEF,
    parameter int LANE_W    = $clog2(LANE_N),
    parameter int TIMEOUT_N = TIMEOUT_N_DEF
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [LANE_N-1:0]        lock_v_i,
    input  logic [LANE_N*LANE_N-1:0] lane_i,
    input  logic [LANE_N-1:0]        slip_v_i,
    input  logic                     deskew_done_i,
    output logic                     map_v_o,
    output logic [LANE_N*LANE_W-1:0] map_o,
    output logic                     deskew_v_o,
    output logic                     align_v_o,
    output logic [LANE_N-1:0]        restart_o,
    output logic                     map_err_o
);

    localparam int               TMR_W    = $clog2(TIMEOUT_N + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_N - 1);

    am_state_e              r_state;
    logic [TMR_W-1:0]       r_timer;

    am_state_e              w_state_nxt;
    logic [TMR_W-1:0]       w_timer_nxt;
    logic                   w_map_v_nxt;
    logic [LANE_N*LANE_W-1:0] w_map_nxt;
    logic                   w_deskew_nxt;
    logic                   w_align_nxt;
    logic [LANE_N-1:0]      w_restart_nxt;
    logic                   w_err_nxt;

    logic                   w_perm_ok;
    logic [LANE_N*LANE_W-1:0] w_map_enc;
    logic                   w_all_lock;
    logic                   w_any_slip;
    logic                   w_mismatch;

    am_lane_map_chk #(
        .LANE_N (LANE_N),
        .LANE_W (LANE_W)
    ) u_map_chk (
        .i_lane    (lane_i),
        .o_perm_ok (w_perm_ok),
        .o_map     (w_map_enc)
    );

    assign w_all_lock = &lock_v_i;
    assign w_any_slip = |slip_v_i;
    // Identities are only meaningful while every lane is locked.
    assign w_mismatch = w_all_lock && (!w_perm_ok || (w_map_enc != map_o));

    // Next-state and next-output decisions; loss beats deskew done beats timeout.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_map_v_nxt   = map_v_o;
        w_map_nxt     = map_o;
        w_deskew_nxt  = deskew_v_o;
        w_align_nxt   = align_v_o;
        w_restart_nxt = '0;
        w_err_nxt     = 1'b0;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_all_lock) begin
                    w_state_nxt = ST_CHECK;
                    w_timer_nxt = '0;
                end else if (r_timer == TMR_LAST) begin
                    w_restart_nxt = ~lock_v_i;
                    w_timer_nxt   = '0;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            ST_CHECK: begin
                w_timer_nxt = '0;
                if (!w_all_lock || w_any_slip) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (w_perm_ok) begin
                    w_map_nxt    = w_map_enc;
                    w_map_v_nxt  = 1'b1;
                    w_deskew_nxt = 1'b1;
                    w_state_nxt  = ST_DESKEW;
                end else begin
                    w_err_nxt     = 1'b1;
                    w_restart_nxt = '1;
                    w_state_nxt   = ST_WAIT_LOCK;
                end
            end
            ST_DESKEW: begin
                if (!w_all_lock || w_any_slip) begin
                    w_state_nxt  = ST_WAIT_LOCK;
                    w_timer_nxt  = '0;
                    w_map_v_nxt  = 1'b0;
                    w_deskew_nxt = 1'b0;
                    w_align_nxt  = 1'b0;
                end else if (deskew_done_i) begin
                    w_state_nxt = ST_ALIGNED;
                    w_timer_nxt = '0;
                    w_align_nxt = 1'b1;
                end else if (r_timer == TMR_LAST) begin
                    w_restart_nxt = '1;
                    w_state_nxt   = ST_WAIT_LOCK;
                    w_timer_nxt   = '0;
                    w_map_v_nxt   = 1'b0;
                    w_deskew_nxt  = 1'b0;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            ST_ALIGNED: begin
                w_timer_nxt = '0;
                if (!w_all_lock || w_any_slip || w_mismatch) begin
                    w_err_nxt    = w_mismatch;
                    w_state_nxt  = ST_WAIT_LOCK;
                    w_map_v_nxt  = 1'b0;
                    w_deskew_nxt = 1'b0;
                    w_align_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = ST_WAIT_LOCK;
                w_timer_nxt  = '0;
                w_map_v_nxt  = 1'b0;
                w_deskew_nxt = 1'b0;
                w_align_nxt  = 1'b0;
            end
        endcase
    end

    // Register state, timer and every output so nothing leaves combinationally.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= ST_WAIT_LOCK;
            r_timer    <= '0;
            map_v_o    <= 1'b0;
            map_o      <= '0;
            deskew_v_o <= 1'b0;
            align_v_o  <= 1'b0;
            restart_o  <= '0;
            map_err_o  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            map_v_o    <= w_map_v_nxt;
            map_o      <= w_map_nxt;
            deskew_v_o <= w_deskew_nxt;
            align_v_o  <= w_align_nxt;
            restart_o  <= w_restart_nxt;
            map_err_o  <= w_err_nxt;
        end
    end

endmodule

// File: doc/am_align_ctrl_rx.md
# am_align_ctrl_rx

Receive-side multi-lane alignment controller for the 40GBASE-R PCS, placed above the per-physical-lane alignment marker lock instances and ahead of the deskew buffer and lane reorder mux. It collects per-lane AM lock status and PCS lane identities and checks that the identities form a valid permutation. It then configures the reorder map, sequences the deskew buffer, and reports overall alignment status. It restarts lanes that fail to lock within a timeout, or that report conflicting identities.

## Interface
- LANE_N, 4, number of physical/PCS lanes
- LANE_W, $clog2(LANE_N), lane index width
- TIMEOUT_N, 65535, cycles allowed in WAIT_LOCK or DESKEW before restart
- clk  in  1  clock, all logic on rising edge
- nreset  in  1  reset, asynchronous, active-low
- lock_v_i  in  LANE_N  per-physical-lane AM lock, level
- lane_i  in  LANE_N*LANE_N  per-physical-lane one-hot PCS lane id; physical lane p at [p*LANE_N +: LANE_N]; meaningful only when lock_v_i[p]
- slip_v_i  in  LANE_N  per-lane slip pulse from AM lock
- deskew_done_i  in  1  deskew buffer aligned, level
- map_v_o  out  1  map_o valid
- map_o  out  LANE_N*LANE_W  for PCS lane l, physical lane index at [l*LANE_W +: LANE_W]
- deskew_v_o  out  1  deskew buffer enable
- align_v_o  out  1  align status
- restart_o  out  LANE_N  per-lane one-cycle restart pulse to AM lock
- map_err_o  out  1  one-cycle pulse on identity conflict or identity change

## Operation
- States: WAIT_LOCK, CHECK, DESKEW, ALIGNED. Reset state is WAIT_LOCK.
- All outputs are registered. Reset value of every output is 0, and the timer is 0.
- WAIT_LOCK
  - The timer increments every cycle.
  - If &lock_v_i, go to CHECK.
  - Else, if the timer equals TIMEOUT_N-1: pulse restart_o for every lane with lock_v_i low, clear the timer, stay in WAIT_LOCK.
- CHECK (one cycle)
  - Requires &lock_v_i, every lane_i slice one-hot, and OR of all slices equal to all ones.
  - Pass: capture map_o (encode each slice into its PCS lane slot), set map_v_o and deskew_v_o, go to DESKEW.
  - Fail: pulse map_err_o and restart_o = all ones, go to WAIT_LOCK.
- DESKEW
  - The timer increments every cycle.
  - deskew_done_i → ALIGNED, set align_v_o.
  - Timeout: restart_o = all ones, clear map_v_o and deskew_v_o, go to WAIT_LOCK.
- ALIGNED
  - Hold the outputs.
  - Each cycle, compare every lane_i slice against the captured map. A mismatch pulses map_err_o.
- Loss condition, evaluated in CHECK, DESKEW and ALIGNED: any lock_v_i low, any slip_v_i, or (ALIGNED only) a map mismatch.
  - Next cycle: WAIT_LOCK, with align_v_o, deskew_v_o, map_v_o cleared.
  - restart_o is not driven for a loss; the AM lock instance self-recovers.
  - map_o holds its last value but is not meaningful while map_v_o is 0.
- Priority: loss > deskew_done_i > timeout.
- The timer clears on every state change.

## Timing
- Cycle N: WAIT_LOCK with &lock_v_i. CHECK at N+1. At N+2: DESKEW, with map_v_o=1, deskew_v_o=1, map_o valid.
- deskew_done_i high at cycle M in DESKEW → align_v_o=1 at M+1.
- Loss at cycle K → align_v_o, map_v_o, deskew_v_o all 0 at K+1.
- restart_o and map_err_o are exactly one cycle wide, registered, issued the cycle after the decision.
- Timeout fires on the TIMEOUT_N-th cycle counted in a state.
- Reset assertion mid-operation clears everything asynchronously. The first state after deassertion is WAIT_LOCK with the timer at 0.
- Timer width is $clog2(TIMEOUT_N+1). It never wraps, because it is cleared at TIMEOUT_N-1.

## Structure
- Package am_pkg holds:
  - the state enum
  - LANE_N and LANE_W defaults
  - the default TIMEOUT_N
- Sub-module am_lane_map_chk is purely combinational. It does the one-hot check per slice, the permutation check, and the one-hot → index encoding into map format.
- Both CHECK and the ALIGNED mismatch compare reuse am_lane_map_chk.

## Test plan
- Identity permutation: lanes lock with ids 0001,0010,0100,1000 at cycle 10 → CHECK at 11, map_v_o=1 and map_o={3,2,1,0} packed at 12; deskew_done_i at 20 → align_v_o=1 at 21.
- Swapped lanes: phys0 carries id 0100 and phys2 carries id 0001 → map_o slot0=2, slot2=0, align reached.
- Duplicate id: phys1 and phys3 both report 0010 → map_err_o pulse, restart_o=1111, back in WAIT_LOCK, align_v_o stays 0.
- Timeout with TIMEOUT_N=16: lane2 never locks → restart_o=0100 pulse 16 cycles after entry, repeating every 16 cycles.
- ALIGNED, slip_v_i[1] pulses at cycle K → align_v_o, map_v_o, deskew_v_o all 0 at K+1; simultaneous deskew_done_i in DESKEW is ignored (loss wins).
- nreset asserted while ALIGNED → all outputs 0 immediately; after release, re-acquisition takes 2 cycles to DESKEW.
